// File: rtl/pwm_gen.sv
// pwm_gen: double-buffered PWM driven by an upstream free-running count.
// Define PWM_PERIOD_CNT_EN to add the completed-period counter output.
module pwm_gen #(
  parameter int WIDTH = 4
`ifdef PWM_PERIOD_CNT_EN
  ,
  parameter int PCW = 8
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cnt,
  input  logic             duty_valid,
  input  logic [WIDTH:0]   duty_data,
  output logic             duty_ready,
  output logic             pwm,
  output logic             wrap
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [PCW-1:0]   period_cnt
`endif
);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH:0] MAXD = {1'b1, {WIDTH{1'b0}}};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH:0]   active;
  logic [WIDTH:0]   pending;
  logic             pend_v;
  logic             start;
  logic             accept;
  logic [WIDTH:0]   clamped;
  logic [WIDTH:0]   eff;
  logic             pwm_d;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      SYNC: begin
        if (cnt == '0) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // a count parked at zero must not retrigger
        start = (cnt == '0) && (cnt_q != '0);
      end
    endcase
  end

  always_comb begin
    accept  = duty_valid && !pend_v;
    clamped = (duty_data > MAXD) ? MAXD : duty_data;
    eff     = (start && pend_v) ? pending : active;
    pwm_d   = (state_next == RUN) && ({1'b0, cnt} < eff);
  end

  assign duty_ready = !pend_v;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= SYNC;
      cnt_q <= '0;
      pwm   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      cnt_q <= cnt;
      pwm   <= pwm_d;
      wrap  <= start;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else begin
      if (start && pend_v) begin
        active <= pending;
      end
      // accept only happens with pend_v clear, so it wins over the consume
      if (accept) begin
        pending <= clamped;
        pend_v  <= 1'b1;
      end else if (start) begin
        pend_v  <= 1'b0;
      end
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_cnt <= '0;
    end else if (start && state == RUN) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: scoreboard plus duty-table checks for pwm_gen.
// Covers idle, duty table, back-to-back offers, boundary accept, async reset.
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       duty_valid = 1'b0;
  logic [4:0] duty_data = 5'd0;
  logic       duty_ready;
  logic       pwm;
  logic       wrap;
`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] period_cnt;
`endif

  always #5 clk = ~clk;

  pwm_gen dut (
    .clk        (clk),
    .rstn       (rstn),
    .cnt        (cnt),
    .duty_valid (duty_valid),
    .duty_data  (duty_data),
    .duty_ready (duty_ready),
    .pwm        (pwm),
    .wrap       (wrap)
`ifdef PWM_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  typedef struct {
    bit       p;
    bit       w;
    bit       r;
    bit [7:0] pc;
  } exp_t;

  typedef struct {
    logic [4:0] duty;
    int         high;
  } vec_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  bit         m_run;
  logic [3:0] m_cq;
  logic [4:0] m_act;
  logic [4:0] m_pend;
  bit         m_pv;
  bit [7:0]   m_pc;
  logic [3:0] cval = 4'd9;
  bit         last_acc;

  function automatic logic [4:0] clampf(input logic [4:0] d);
    return (d > 5'd16) ? 5'd16 : d;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // drive one cycle, predict, then compare after the edge
  task automatic cyc(input bit rs, input bit v, input logic [4:0] d);
    exp_t       e;
    exp_t       g;
    bit         st;
    bit         ra;
    bit         bad;
    logic [4:0] ud;
    @(negedge clk);
    rstn       = rs;
    cnt        = cval;
    duty_valid = v;
    duty_data  = d;
    if (!rs) begin
      m_run = 0; m_cq = 0; m_act = 0;
      m_pend = 0; m_pv = 0; m_pc = 0;
      last_acc = 0;
      e = '{p: 0, w: 0, r: 1, pc: 0};
    end else begin
      st = (cnt == 0) && (!m_run || m_cq != 0);
      ud = (st && m_pv) ? m_pend : m_act;
      ra = m_run || (cnt == 0);
      e.p = ra && ({1'b0, cnt} < ud);
      e.w = st;
      last_acc = v && !m_pv;
      if (st && m_run) m_pc = m_pc + 8'd1;
      if (st && m_pv) m_act = m_pend;
      if (last_acc) begin
        m_pend = clampf(d);
        m_pv   = 1;
      end else if (st) begin
        m_pv = 0;
      end
      m_cq  = cnt;
      m_run = ra;
      e.r   = !m_pv;
      e.pc  = m_pc;
    end
    sbq.push_back(e);
    cval = cval + 4'd1;
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    bad = (pwm !== g.p) || (wrap !== g.w) || (duty_ready !== g.r);
`ifdef PWM_PERIOD_CNT_EN
    bad = bad || (period_cnt !== g.pc);
`endif
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL cycle t=%0t cnt=%0d: pwm/wrap/rdy got %b%b%b want %b%b%b",
               $time, cnt, pwm, wrap, duty_ready, g.p, g.w, g.r);
    end
  endtask

  task automatic tick(input bit v, input logic [4:0] d);
    cyc(1'b1, v, d);
  endtask

  task automatic offer(input logic [4:0] d, output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick(1'b1, d);
      ok = last_acc;
    end
  endtask

  task automatic run_until(input logic [3:0] c);
    for (int i = 0; i < 40 && cval != c; i++) tick(1'b0, 5'd0);
    chk("run_until", int'(cval), int'(c));
  endtask

  // wait nw wraps, then check one full period's shape
  task automatic measure(input string nm, input int nw, input int high);
    int w;
    int h;
    bit bad;
    w = 0;
    for (int i = 0; i < 80 && w < nw; i++) begin
      tick(1'b0, 5'd0);
      if (wrap) w++;
    end
    if (w < nw) begin
      chk({nm, " wrap timeout"}, w, nw);
      return;
    end
    h   = int'(pwm);
    bad = (pwm !== (0 < high));
    for (int k = 1; k < 16; k++) begin
      tick(1'b0, 5'd0);
      h += int'(pwm);
      if (pwm !== (k < high)) bad = 1;
    end
    chk(nm, bad ? -1 : h, high);
  endtask

  initial begin
    vec_t tbl[8];
    bit   ok;
    int   w;
    int   h;
    int   n;

    tbl[0] = '{duty: 5'd5,  high: 5};
    tbl[1] = '{duty: 5'd0,  high: 0};
    tbl[2] = '{duty: 5'd16, high: 16};
    tbl[3] = '{duty: 5'd20, high: 16};
    tbl[4] = '{duty: 5'd1,  high: 1};
    tbl[5] = '{duty: 5'd15, high: 15};
    tbl[6] = '{duty: 5'd31, high: 16};
    tbl[7] = '{duty: 5'd8,  high: 8};

    repeat (3) cyc(1'b0, 1'b0, 5'd0);

    w = 0;
    h = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 5'd0);
      w += int'(wrap);
      h += int'(pwm);
    end
    chk("idle wraps", w, 2);
    chk("idle pwm highs", h, 0);
    chk("idle ready", int'(duty_ready), 1);

    for (int i = 0; i < 8; i++) begin
      offer(tbl[i].duty, ok);
      chk($sformatf("accept %0d", tbl[i].duty), int'(ok), 1);
      measure($sformatf("duty %0d", tbl[i].duty), 1, tbl[i].high);
    end

    run_until(4'd5);
    tick(1'b1, 5'd3);
    chk("accept 3", int'(last_acc), 1);
    tick(1'b1, 5'd12);
    chk("12 blocked", int'(last_acc), 0);
    chk("ready low after 3", int'(duty_ready), 0);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1'b1, 5'd12);
      ok = last_acc;
    end
    chk("12 accept cnt", ok ? int'(cnt) : -1, 1);
    measure("duty 12", 1, 12);

    run_until(4'd0);
    tick(1'b1, 5'd9);
    chk("accept 9 at cnt0", int'(last_acc), 1);
    chk("ready low after 9", int'(duty_ready), 0);
    h = int'(pwm);
    for (int k = 1; k < 16; k++) begin
      tick(1'b0, 5'd0);
      h += int'(pwm);
    end
    chk("old duty kept", h, 12);
    measure("duty 9", 1, 9);

    run_until(4'd3);
    offer(5'd2, ok);
    chk("accept 2", int'(ok), 1);
    run_until(4'd7);
    tick(1'b0, 5'd0);
    chk("pre-reset pwm", int'(pwm), 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async pwm", int'(pwm), 0);
    chk("async wrap", int'(wrap), 0);
    chk("async ready", int'(duty_ready), 1);
    repeat (2) cyc(1'b0, 1'b0, 5'd0);
    offer(5'd5, ok);
    chk("accept 5 in sync", int'(ok), 1);
    measure("sync duty 5", 1, 5);
    measure("sync duty 5 again", 1, 5);

`ifdef PWM_PERIOD_CNT_EN
    n = 0;
    while (period_cnt != 8'd255 && n < 5000) begin
      tick(1'b0, 5'd0);
      n++;
    end
    chk("pc reach 255", int'(period_cnt), 255);
    n = 0;
    do begin
      tick(1'b0, 5'd0);
      n++;
    end while (!wrap && n < 40);
    chk("pc wrap", int'(period_cnt), 0);
`else
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
